// File: rtl/vc_iter_mul_if.sv
// Handshake bundle for the iterative multiplier.
//   in_val/in_rdy/in_a/in_b/in_signed : operand request channel
//   out_val/out_rdy/out_prod          : product response channel
// The master modport belongs to the requester/consumer. The slave modport belongs to the multiplier.
interface vc_iter_mul_if #(
    parameter int W = 32
);
    logic           in_val;
    logic           in_rdy;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_signed;
    logic           out_val;
    logic           out_rdy;
    logic [2*W-1:0] out_prod;

    modport master (
        output in_val, in_a, in_b, in_signed, out_rdy,
        input  in_rdy, out_val, out_prod
    );

    modport slave (
        input  in_val, in_a, in_b, in_signed, out_rdy,
        output in_rdy, out_val, out_prod
    );
endinterface

// File: rtl/vc_iter_mul.sv
// Multi-cycle shift-and-add multiplier with val/rdy handshakes.
// The multiplier works on operand magnitudes and retires BPC multiplier bits per CALC cycle.
// If exactly one operand was negative in signed mode, the unit negates the final sum.
// Latency is W/BPC cycles from the accepting edge to out_val, regardless of the data.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset. It aborts any operation in flight.
//   io     : vc_iter_mul_if.slave (operand request channel and product response channel)
module vc_iter_mul #(
    parameter int W   = 32,
    parameter int BPC = 1
) (
    input  logic           clk,
    input  logic           reset,
    vc_iter_mul_if.slave   io
);
    localparam int N  = W / BPC;
    localparam int CW = $clog2(N + 1);

    generate
        if (!((BPC == 1 || BPC == 2 || BPC == 4) && (W % BPC == 0))) begin : g_bad_param
            $error("vc_iter_mul: BPC=%0d is illegal for W=%0d", BPC, W);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [2*W-1:0] a_sh;      // multiplicand, pre-shifted to the current digit position
    logic [W-1:0]   b_sh;      // multiplier, consumed from the bottom
    logic [2*W-1:0] acc;
    logic [2*W-1:0] pp;
    logic [2*W-1:0] sum;
    logic [2*W-1:0] prod_q;
    logic [CW-1:0]  cnt;
    logic           neg;
    logic           accept;
    logic           last;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;

    // Negating -2^(W-1) gives 2^(W-1). That value is correct when the W bits are read as unsigned.
    assign mag_a  = (io.in_signed && io.in_a[W-1]) ? -io.in_a : io.in_a;
    assign mag_b  = (io.in_signed && io.in_b[W-1]) ? -io.in_b : io.in_b;

    assign io.in_rdy   = (state == IDLE) && !reset;
    assign io.out_val  = (state == DONE);
    assign io.out_prod = prod_q;

    assign accept = io.in_val && io.in_rdy;
    assign last   = (cnt == CW'(1));

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = CALC;
            CALC:    if (last)       state_nxt = DONE;
            DONE:    if (io.out_rdy) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Partial product for one BPC-bit digit, formed as a sum of shifted multiplicands.
    always_comb begin
        pp = '0;
        for (int i = 0; i < BPC; i++) begin
            if (b_sh[i]) pp = pp + (a_sh << i);
        end
        sum = acc + pp;
    end

    // NOTE: sequential state uses non-blocking assignments only. This keeps every register update atomic at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the datapath registers are reset too, so a reset mid-operation can never leave a stale or partial product visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            prod_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh <= {{W{1'b0}}, mag_a};
                        b_sh <= mag_b;
                        acc  <= '0;
                        cnt  <= CW'(N);
                        neg  <= io.in_signed & (io.in_a[W-1] ^ io.in_b[W-1]);
                    end
                end
                CALC: begin
                    acc  <= sum;
                    a_sh <= a_sh << BPC;
                    b_sh <= b_sh >> BPC;
                    cnt  <= cnt - CW'(1);
                    if (last) prod_q <= neg ? -sum : sum;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vc_iter_mul.sv
module tb_vc_iter_mul;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vc_iter_mul_if #(.W(8))  if8  ();
    vc_iter_mul_if #(.W(32)) if32 ();
    vc_iter_mul_if #(.W(16)) if16 ();

    vc_iter_mul #(.W(8),  .BPC(1)) dut8  (.clk(clk), .reset(reset), .io(if8.slave));
    vc_iter_mul #(.W(32), .BPC(4)) dut32 (.clk(clk), .reset(reset), .io(if32.slave));
    vc_iter_mul #(.W(16), .BPC(2)) dut16 (.clk(clk), .reset(reset), .io(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete operation on the 8-bit unit with out_rdy held high.
    // lat counts cycles from the accepting edge to out_val. rdy_bad counts busy cycles that showed in_rdy=1.
    task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [15:0] p, output int lat, output int rdy_bad);
        int w;
        if8.in_a = a; if8.in_b = b; if8.in_signed = s;
        if8.in_val = 1'b1; if8.out_rdy = 1'b1;
        w = 0;
        while (!if8.in_rdy && w < 100) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        if8.in_val = 1'b0;
        if8.in_a = 8'($urandom); if8.in_b = 8'($urandom); if8.in_signed = 1'($urandom);
        lat = 0; rdy_bad = 0;
        while (!if8.out_val && lat < 100) begin
            if (if8.in_rdy) rdy_bad++;
            @(posedge clk); #1; lat++;
        end
        if (if8.in_rdy) rdy_bad++;
        p = if8.out_prod;
        @(posedge clk); #1;
    endtask

    task automatic do32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] p, output int lat);
        int w;
        if32.in_a = a; if32.in_b = b; if32.in_signed = s;
        if32.in_val = 1'b1; if32.out_rdy = 1'b1;
        w = 0;
        while (!if32.in_rdy && w < 100) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        if32.in_val = 1'b0;
        lat = 0;
        while (!if32.out_val && lat < 100) begin @(posedge clk); #1; lat++; end
        p = if32.out_prod;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (if8.in_rdy !== 1'b0 || if8.out_val !== 1'b0 || if8.out_prod !== 16'h0) begin
            errors++;
            $display("FAIL reset8: rdy=%b val=%b prod=%h, required 0 0 0000", if8.in_rdy, if8.out_val, if8.out_prod);
        end
        checks++;
        if (if32.in_rdy !== 1'b0 || if32.out_val !== 1'b0 || if32.out_prod !== 64'h0) begin
            errors++;
            $display("FAIL reset32: rdy=%b val=%b prod=%h, required 0 0 0", if32.in_rdy, if32.out_val, if32.out_prod);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if8.in_rdy !== 1'b1 || if16.in_rdy !== 1'b1 || if32.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: %b%b%b, required 111", if8.in_rdy, if16.in_rdy, if32.in_rdy);
        end
    endtask

    task automatic test_unsigned8();
        logic [15:0] p; int lat, bad;
        do8(8'hFF, 8'hFF, 1'b0, p, lat, bad);
        checks++;
        if (p !== 16'hFE01) begin errors++; $display("FAIL u8_prod: got %h required fe01", p); end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL u8_latency: got %0d required 8", lat); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL u8_busy_rdy: in_rdy high in %0d busy cycles, required 0", bad); end
        checks++;
        if (if8.out_val !== 1'b0 || if8.out_prod !== 16'hFE01) begin
            errors++;
            $display("FAIL u8_after_hs: val=%b prod=%h, required 0 fe01", if8.out_val, if8.out_prod);
        end
    endtask

    task automatic test_signed8();
        logic [7:0]  av [4] = '{8'hFD, 8'h80, 8'h80, 8'h07};
        logic [7:0]  bv [4] = '{8'h05, 8'h80, 8'h7F, 8'h00};
        logic [15:0] ev [4] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0000};
        logic [15:0] p; int lat, bad;
        for (int i = 0; i < 4; i++) begin
            do8(av[i], bv[i], 1'b1, p, lat, bad);
            checks++;
            if (p !== ev[i] || lat !== 8) begin
                errors++;
                $display("FAIL s8_pair%0d: got %h lat %0d, required %h lat 8", i, p, lat, ev[i]);
            end
        end
    endtask

    task automatic test_wide32();
        logic [63:0] p; int lat;
        do32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, lat);
        checks++;
        if (p !== 64'hFFFFFFFE00000001 || lat !== 8) begin
            errors++;
            $display("FAIL w32_unsigned: got %h lat %0d, required fffffffe00000001 lat 8", p, lat);
        end
        do32(32'h80000000, 32'h00000002, 1'b1, p, lat);
        checks++;
        if (p !== 64'hFFFFFFFF00000000 || lat !== 8) begin
            errors++;
            $display("FAIL w32_signed: got %h lat %0d, required ffffffff00000000 lat 8", p, lat);
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] p; int w, lat, bad, stable_bad;
        if8.in_a = 8'd13; if8.in_b = 8'd11; if8.in_signed = 1'b0;
        if8.in_val = 1'b1; if8.out_rdy = 1'b0;
        w = 0;
        while (!if8.in_rdy && w < 100) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        if8.in_a = 8'd2; if8.in_b = 8'd3;      // a request that must be ignored while busy
        w = 0;
        while (!if8.out_val && w < 100) begin @(posedge clk); #1; w++; end
        stable_bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (if8.out_val !== 1'b1 || if8.out_prod !== 16'd143 || if8.in_rdy !== 1'b0) stable_bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (stable_bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles (val=%b prod=%h rdy=%b), required 0", stable_bad, if8.out_val, if8.out_prod, if8.in_rdy);
        end
        if8.out_rdy = 1'b1;
        if8.in_a = 8'd20; if8.in_b = 8'd10;
        @(posedge clk); #1;
        checks++;
        if (if8.in_rdy !== 1'b1 || if8.out_val !== 1'b0 || if8.out_prod !== 16'd143) begin
            errors++;
            $display("FAIL bp_release: rdy=%b val=%b prod=%h, required 1 0 008f", if8.in_rdy, if8.out_val, if8.out_prod);
        end
        @(posedge clk); #1;
        if8.in_val = 1'b0;
        checks++;
        if (if8.in_rdy !== 1'b0) begin errors++; $display("FAIL bp_new_accept: rdy=%b, required 0", if8.in_rdy); end
        lat = 0;
        while (!if8.out_val && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++;
        if (if8.out_prod !== 16'd200 || lat !== 8) begin
            errors++;
            $display("FAIL bp_new_prod: got %h lat %0d, required 00c8 lat 8", if8.out_prod, lat);
        end
        @(posedge clk); #1;
        bad = 0; p = '0;
    endtask

    task automatic test_back_to_back();
        int acc_cyc [$];
        int w;
        if8.in_a = 8'd9; if8.in_b = 8'd9; if8.in_signed = 1'b0;
        if8.in_val = 1'b1; if8.out_rdy = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (if8.in_rdy) acc_cyc.push_back(c);
            @(posedge clk); #1;
        end
        if8.in_val = 1'b0;
        checks++;
        if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] !== 10) begin
            errors++;
            $display("FAIL b2b_spacing: %0d accepts, spacing %0d, required 10",
                     acc_cyc.size(), (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        end
        w = 0;
        while (!if8.in_rdy && w < 100) begin @(posedge clk); #1; w++; end
        checks++;
        if (if8.out_prod !== 16'd81) begin errors++; $display("FAIL b2b_prod: got %h required 0051", if8.out_prod); end
    endtask

    task automatic test_async_reset();
        logic [15:0] p; int w, lat, bad;
        if8.in_a = 8'd200; if8.in_b = 8'd100; if8.in_signed = 1'b0;
        if8.in_val = 1'b1; if8.out_rdy = 1'b1;
        w = 0;
        while (!if8.in_rdy && w < 100) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        if8.in_val = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (if8.out_val !== 1'b0 || if8.out_prod !== 16'h0 || if8.in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL arst_now: val=%b prod=%h rdy=%b, required 0 0000 0", if8.out_val, if8.out_prod, if8.in_rdy);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (if8.in_rdy !== 1'b1 || if8.out_val !== 1'b0) begin
            errors++;
            $display("FAIL arst_release: rdy=%b val=%b, required 1 0", if8.in_rdy, if8.out_val);
        end
        do8(8'd6, 8'd7, 1'b0, p, lat, bad);
        checks++;
        if (p !== 16'd42 || lat !== 8) begin
            errors++;
            $display("FAIL arst_next_op: got %h lat %0d, required 002a lat 8", p, lat);
        end
    endtask

    // Random traffic on the 16-bit unit. The reference is the plain integer product.
    task automatic test_random16();
        logic [31:0] exp_q [$];
        logic [31:0] pend;
        logic [15:0] a, b;
        logic        s;
        longint      sa, sb;
        int          issued, done, cyc;
        logic        acc_now, hs_now;
        issued = 0; done = 0; cyc = 0; pend = '0;
        if16.in_val = 1'b0; if16.out_rdy = 1'b0;
        while (done < 1000 && cyc < 60000) begin
            if (issued < 1000 && !if16.in_val && $urandom_range(0, 3) != 0) begin
                a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
                case ($urandom_range(0, 7))
                    0: a = 16'h8000;
                    1: b = 16'h0000;
                    2: a = 16'hFFFF;
                    default: ;
                endcase
                sa = longint'($signed(a)); sb = longint'($signed(b));
                pend = s ? 32'(sa * sb) : 32'(a) * 32'(b);
                if16.in_a = a; if16.in_b = b; if16.in_signed = s; if16.in_val = 1'b1;
            end
            if16.out_rdy = ($urandom_range(0, 2) != 0);
            acc_now = if16.in_val && if16.in_rdy;
            hs_now  = if16.out_val && if16.out_rdy;
            if (hs_now) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious: product %h with no pending request", if16.out_prod);
                end else if (if16.out_prod !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rnd_prod%0d: got %h required %h", done, if16.out_prod, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                done++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                exp_q.push_back(pend);
                issued++;
                if16.in_val = 1'b0;
                if16.in_a = 16'($urandom); if16.in_b = 16'($urandom);
            end
        end
        checks++;
        if (issued !== 1000 || done !== 1000 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL rnd_balance: issued %0d done %0d pending %0d, required 1000 1000 0", issued, done, exp_q.size());
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        if8.in_val = 1'b0;  if8.in_a = '0;  if8.in_b = '0;  if8.in_signed = 1'b0;  if8.out_rdy = 1'b0;
        if16.in_val = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_signed = 1'b0; if16.out_rdy = 1'b0;
        if32.in_val = 1'b0; if32.in_a = '0; if32.in_b = '0; if32.in_signed = 1'b0; if32.out_rdy = 1'b0;
        test_reset();
        test_unsigned8();
        test_signed8();
        test_wide32();
        test_back_pressure();
        test_back_to_back();
        test_async_reset();
        test_random16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
